// File: rtl/mod_exp_if.sv
// Operand/result handshake between the RSA controller and the modular-exponentiation core.
// The master drives the operands and start; the slave returns status and result.
interface mod_exp_if #(
  parameter int W = 64
);
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] mod;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;

  modport master (
    output start, base, exp, mod,
    input  busy, done, err, result
  );

  modport slave (
    input  start, base, exp, mod,
    output busy, done, err, result
  );
endinterface

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation with fixed W*W-cycle latency.
// Two bit-serial interleaved multipliers (R*B and B*B) share one step index.
module mod_exp_engine #(
  parameter int W = 64
) (
  input  logic       clk,
  input  logic       rst,
  mod_exp_if.slave   bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  n_reg, b_reg, e_reg, r_reg, result_reg;
  logic          err_reg;
  logic [CW-1:0] k_reg, i_reg;
  logic [W+1:0]  acc_reg  [2];
  logic [W+1:0]  acc_next [2];
  logic [W-1:0]  mul_x    [2];
  logic          bad_ops, pass_end, last_pass;
  logic [W-1:0]  r_pass;

  // Slot 0 is multiplier A (R*B), slot 1 is multiplier S (B*B); both use B as multiplicand.
  assign mul_x[0] = r_reg;
  assign mul_x[1] = b_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mul
      logic [W+1:0] sum, red1, nxt;
      always_comb begin
        sum  = (acc_reg[gi] << 1) + (mul_x[gi][i_reg] ? {2'b00, b_reg} : '0);
        red1 = (sum >= {2'b00, n_reg}) ? sum - {2'b00, n_reg} : sum;
        nxt  = (red1 >= {2'b00, n_reg}) ? red1 - {2'b00, n_reg} : red1;
      end
      assign acc_next[gi] = nxt;
    end
  endgenerate

  assign bad_ops   = (bus.mod < W'(2)) || (bus.base >= bus.mod);
  assign pass_end  = (i_reg == '0);
  assign last_pass = (k_reg == LAST);
  assign r_pass    = e_reg[k_reg] ? acc_next[0][W-1:0] : r_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = bad_ops ? FIN : RUN;
      RUN:     if (pass_end && last_pass) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg      <= '0;
      b_reg      <= '0;
      e_reg      <= '0;
      r_reg      <= '0;
      k_reg      <= '0;
      i_reg      <= '0;
      acc_reg[0] <= '0;
      acc_reg[1] <= '0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            n_reg      <= bus.mod;
            b_reg      <= bus.base;
            e_reg      <= bus.exp;
            r_reg      <= W'(1);
            k_reg      <= '0;
            i_reg      <= LAST;
            acc_reg[0] <= '0;
            acc_reg[1] <= '0;
            err_reg    <= bad_ops;
            result_reg <= '0;
          end
        end
        RUN: begin
          if (pass_end) begin
            b_reg      <= acc_next[1][W-1:0];
            r_reg      <= r_pass;
            k_reg      <= k_reg + CW'(1);
            i_reg      <= LAST;
            acc_reg[0] <= '0;
            acc_reg[1] <= '0;
            // Result is loaded on the final edge so it is already valid during FIN.
            if (last_pass) result_reg <= r_pass;
          end else begin
            i_reg      <= i_reg - CW'(1);
            acc_reg[0] <= acc_next[0];
            acc_reg[1] <= acc_next[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == FIN);
  assign bus.err    = err_reg;
  assign bus.result = result_reg;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine at W=16: expected results are queued at start
// and compared (value, err, done cycle, busy length) when done pulses.
module tb_mod_exp_engine;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_exp_if #(.W(W)) bus ();
  mod_exp_engine #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] b, e, m, res;
    logic         err;
    longint       due;
    int           busy_len;
  } op_t;

  op_t    sb[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, e, m);
    longint r = 1;
    longint x = longint'(b);
    for (int k = 0; k < W; k++) begin
      if (e[k]) r = (r * x) % longint'(m);
      x = (x * x) % longint'(m);
    end
    return W'(r);
  endfunction

  function automatic op_t make_op(input logic [W-1:0] b, e, m, res, input logic err, input longint edge_cyc);
    op_t o;
    o.b = b; o.e = e; o.m = m; o.res = res; o.err = err;
    o.busy_len = err ? 0 : W * W;
    o.due = edge_cyc + longint'(o.busy_len);
    return o;
  endfunction

  // Monitor: one line per completed transaction.
  initial forever begin
    op_t o;
    @(negedge clk);
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          o = sb.pop_front();
          check("result", bus.result, o.res);
          check("err", bus.err, o.err);
          check("done_cycle", cyc, o.due);
          check("busy_len", busy_cnt, o.busy_len);
          check("busy_in_fin", bus.busy, 0);
          $display("op %0d^%0d mod %0d -> %0d err=%0b at cycle %0d",
                   o.b, o.e, o.m, bus.result, bus.err, cyc);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic issue(input logic [W-1:0] b, e, m, res, input logic err);
    bus.base  = b;
    bus.exp   = e;
    bus.mod   = m;
    bus.start = 1'b1;
    sb.push_back(make_op(b, e, m, res, err, cyc + 1));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] b, e, m, res, input logic err);
    issue(b, e, m, res, err);
    wait_idle(W * W + 20);
    repeat (3) @(negedge clk);
    check("hold_result", bus.result, res);
    check("hold_err", bus.err, err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] rb, re, rm;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    bus.mod   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_result", bus.result, 0);
    @(posedge clk);
    #1;

    run_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0);

    // RSA round trip, second start right after the first done
    issue(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
    wait_idle(W * W + 20);
    issue(16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0);
    wait_idle(W * W + 20);

    run_op(16'd7, 16'd0, 16'd13, 16'd1, 1'b0);
    run_op(16'd0, 16'd5, 16'd13, 16'd0, 1'b0);
    run_op(16'd3, 16'd65520, 16'd65521, 16'd1, 1'b0);
    run_op(16'd5, 16'd3, 16'd1, 16'd0, 1'b1);
    run_op(16'd20, 16'd4, 16'd13, 16'd0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      rm = W'($urandom_range(2, 65535));
      rb = W'($urandom_range(0, int'(rm) - 1));
      re = W'($urandom);
      run_op(rb, re, rm, ref_pow(rb, re, rm), 1'b0);
    end

    // start held high for 300 cycles: one run, FIN start ignored, second accepted after FIN
    bus.base  = 16'd4;
    bus.exp   = 16'd13;
    bus.mod   = 16'd497;
    bus.start = 1'b1;
    sb.push_back(make_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, cyc + 1));
    sb.push_back(make_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, cyc + 1 + W * W + 2));
    repeat (300) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle(2 * W * W + 40);

    // reset in the middle of a run aborts it with no done
    issue(16'd4, 16'd13, 16'd497, 16'd445, 1'b0);
    repeat (98) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_err", bus.err, 0);
    repeat (300) @(posedge clk);
    #1;
    run_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
